keccak_squeeze: RTL

Squeeze-side output stage of the Keccak sponge used by the SHAKE/SHA3 paths of the Kyber768 accelerator. It reads the rate lanes of the 25-lane permutation state (after theta/rho/pi/chi/iota have run) and streams them out as 64-bit words under a valid/ready handshake. When the rate portion is used up, it requests another permutation and waits for it. It stops after a programmed number of words. The absorb stage writes lanes into the state; this block reads them back out.

---
 rtl/keccak_squeeze_if.sv | 24 ++
 rtl/keccak_squeeze.sv | 131 +++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_if.sv
// Squeeze-side handshake bundle: start/length, permutation request/done, state lanes, output stream.
interface keccak_squeeze_if;
    logic                  start;
    logic [15:0]           out_words;
    logic [24:0][63:0]     state_in;
    logic                  perm_req;
    logic                  perm_done;
    logic [63:0]           dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  dout_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, out_words, state_in, perm_done, dout_ready,
        input  perm_req, dout, dout_valid, dout_last, busy, done
    );

    modport slave (
        input  start, out_words, state_in, perm_done, dout_ready,
        output perm_req, dout, dout_valid, dout_last, busy, done
    );
endinterface

// File: rtl/keccak_squeeze.sv
// Keccak squeeze stage: buffers the rate lanes of the permutation state and streams them
// as 64-bit words, requesting a fresh permutation whenever the rate portion is exhausted.
module keccak_squeeze #(
    parameter int unsigned RATE_LANES = 21
) (
    input  logic             clk,
    input  logic             rst,
    keccak_squeeze_if.slave  sq
);

    localparam int unsigned LW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_PERM_WAIT,
        S_FINISH
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   rbuf_q [RATE_LANES];
    logic [63:0]   rbuf_d [RATE_LANES];
    logic [LW-1:0] lane_q, lane_d;
    logic [15:0]   rem_q, rem_d;

    logic [63:0]   dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          preq_q, preq_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          hs;
    logic          latch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rbuf_q  <= '{default: '0};
            lane_q  <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            preq_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            preq_q  <= preq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        latch   = 1'b0;
        hs      = (state_q == S_STREAM) && valid_q && sq.dout_ready;
        unique case (state_q)
            S_IDLE: begin
                // busy_q is still high for the cycle right after FINISH
                if (sq.start && !busy_q) begin
                    if (sq.out_words != 16'd0) begin
                        latch   = 1'b1;
                        rem_d   = sq.out_words;
                        lane_d  = '0;
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_STREAM: begin
                if (hs) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_FINISH;
                    end else if (lane_q == LW'(RATE_LANES - 1)) begin
                        lane_d  = '0;
                        state_d = S_PERM_WAIT;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_PERM_WAIT: begin
                if (sq.perm_done) begin
                    latch   = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        rbuf_d = rbuf_q;
        if (latch) begin
            for (int unsigned i = 0; i < RATE_LANES; i++) begin
                rbuf_d[LW'(i)] = sq.state_in[5'(i)];
            end
        end
    end

    // Words are loaded from the buffer one cycle after it is latched, so valid rises on
    // the second cycle in STREAM; leaving STREAM drops valid on the handshake edge itself.
    always_comb begin
        valid_d = (state_q == S_STREAM) && (state_d == S_STREAM);
        dout_d  = valid_d ? rbuf_q[lane_d] : dout_q;
        last_d  = valid_d && (rem_d == 16'd1);
        preq_d  = (state_d == S_PERM_WAIT);
        busy_d  = (state_q != S_IDLE);
        done_d  = (state_q == S_FINISH);
    end

    assign sq.dout       = dout_q;
    assign sq.dout_valid = valid_q;
    assign sq.dout_last  = last_q;
    assign sq.perm_req   = preq_q;
    assign sq.busy       = busy_q;
    assign sq.done       = done_q;

endmodule
